// File: rtl/vending_pkg.sv
// Shared definitions for the vending-machine front end.
// Holds the keypad FSM state encoding, the frame classification type,
// the key-code map used by the vending FSM, and the frame classifier helpers.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_class_e;

  localparam logic [3:0] KEY_COIN_1  = 4'd0;
  localparam logic [3:0] KEY_COIN_5  = 4'd1;
  localparam logic [3:0] KEY_COIN_10 = 4'd2;
  localparam logic [3:0] KEY_GOODS_A = 4'd4;
  localparam logic [3:0] KEY_GOODS_B = 4'd5;
  localparam logic [3:0] KEY_QTY     = 4'd6;
  localparam logic [3:0] KEY_OK      = 4'd14;
  localparam logic [3:0] KEY_CANCEL  = 4'd15;

  // Classify a full-keypad frame by how many keys read as closed.
  function automatic frame_class_e classify_frame(input logic [15:0] snap);
    logic [4:0] ones;
    ones = 5'd0;
    for (int i = 0; i < 16; i++) begin
      ones = ones + {4'd0, snap[i]};
    end
    if (ones == 5'd0) begin
      return FRAME_NONE;
    end else if (ones == 5'd1) begin
      return FRAME_SINGLE;
    end else begin
      return FRAME_MULTI;
    end
  endfunction

  // Index of the set bit; only meaningful when the frame is FRAME_SINGLE.
  function automatic logic [3:0] frame_code(input logic [15:0] snap);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        code = 4'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the 4-bit keypad column sense lines.
// Ports: clk - sampling clock; rst_n - async active-low reset (outputs 4'b1111,
// i.e. all columns idle-high); d - asynchronous input; q - synchronized output.
module sync_2ff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with whole-frame debounce.
// Ports: sys_clk - system clock; sys_rst_n - async active-low reset;
// key_row - active-low row drive (one row low at a time);
// key_col - active-low column sense (asynchronous, pulled up);
// key_code - last accepted key (row*4 + col); key_valid - one-cycle accept pulse;
// key_held - high from accepted press until the release is accepted.
module keypad_scan
  import vending_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 100_000,
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  output logic [3:0] key_row,
  input  logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned     DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_FRAMES);

  logic [3:0]       col_sync_s;
  logic             tick_s;
  logic             frame_done_s;
  frame_class_e     frame_cls_s;
  logic [3:0]       frame_code_s;
  logic [3:0]       cnt_inc_s;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_row_q, key_row_d;
  logic [15:0]      snapshot_q, snapshot_d;
  kp_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  sync_2ff u_col_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_col),
    .q     (col_sync_s)
  );

  // Row-slot divider, row stepping and per-row snapshot capture.
  always_comb begin
    tick_s     = (div_q == DIV_LAST);
    div_d      = tick_s ? '0 : div_q + DIV_W'(1);
    row_idx_d  = tick_s ? row_idx_q + 2'd1 : row_idx_q;
    key_row_d  = ~(4'b0001 << row_idx_d);
    snapshot_d = snapshot_q;
    if (tick_s) begin
      // Columns are active-low; store closed keys as ones.
      snapshot_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_s;
    end else begin
      snapshot_d = snapshot_q;
    end
    // The row-3 tick completes the frame; classify including that row's sample.
    frame_done_s = tick_s && (row_idx_q == 2'd3);
    frame_cls_s  = classify_frame(snapshot_d);
    frame_code_s = frame_code(snapshot_d);
  end

  // Debounce / press / release state machine, stepped once per completed frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_inc_s   = cnt_q + 4'd1;
    if (frame_done_s) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_cls_s == FRAME_SINGLE) begin
            cand_d = frame_code_s;
            if (DEB_N <= 4'd1) begin
              state_d     = ST_PRESSED;
              cnt_d       = 4'd0;
              key_code_d  = frame_code_s;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if ((frame_cls_s == FRAME_SINGLE) && (frame_code_s == cand_q)) begin
            if (cnt_inc_s >= DEB_N) begin
              state_d     = ST_PRESSED;
              cnt_d       = 4'd0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          // Any key activity while held keeps us here; no roll-over.
          if (frame_cls_s == FRAME_NONE) begin
            if (DEB_N <= 4'd1) begin
              state_d    = ST_IDLE;
              cnt_d      = 4'd0;
              key_held_d = 1'b0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = 4'd1;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        ST_RELEASE: begin
          if (frame_cls_s == FRAME_NONE) begin
            if (cnt_inc_s >= DEB_N) begin
              state_d    = ST_IDLE;
              cnt_d      = 4'd0;
              key_held_d = 1'b0;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          cnt_d      = 4'd0;
          key_held_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q       <= '0;
      row_idx_q   <= 2'd0;
      key_row_q   <= 4'b1110;
      snapshot_q  <= 16'd0;
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      key_row_q   <= key_row_d;
      snapshot_q  <= snapshot_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_row   = key_row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
